// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush and bubble zeroing of control bits.
// Optional bubble-cycle counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_d,
    output logic            ready_d,
    input  logic            RegWriteD,
    input  logic            ALUSrcD,
    input  logic            MemWriteD,
    input  logic            ResultSrcD,
    input  logic            BranchD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1_D,
    input  logic [XLEN-1:0] RD2_D,
    input  logic [XLEN-1:0] Imm_Ext_D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      RS1_D,
    input  logic [4:0]      RS2_D,
    input  logic [4:0]      RD_D,
    input  logic            flush_e,
    input  logic            ready_e,
    output logic            valid_e,
    output logic            RegWriteE,
    output logic            ALUSrcE,
    output logic            MemWriteE,
    output logic            ResultSrcE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RS1_E,
    output logic [4:0]      RS2_E,
    output logic [4:0]      RD_E
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]     bubble_cnt
`endif
);

    typedef struct packed {
        logic       regWrite;
        logic       aluSrc;
        logic       memWrite;
        logic       resultSrc;
        logic       branch;
        logic [2:0] aluControl;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } data_t;

    ctrl_t ctrlD, ctrlE;
    data_t dataD, dataE;
    logic  validQ, nextValid, xfer;

    assign ctrlD = '{RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, ALUControlD};
    assign dataD = '{RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D, RS1_D, RS2_D, RD_D};

    assign ready_d = ~validQ | ready_e;
    assign xfer    = valid_d & ready_d & ~flush_e;

    // Flush beats transfer; an accepted bundle with nothing behind it drains to a bubble.
    always_comb begin
        nextValid = validQ;
        if (flush_e)               nextValid = 1'b0;
        else if (xfer)             nextValid = 1'b1;
        else if (validQ & ready_e) nextValid = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validQ <= 1'b0;
            ctrlE  <= '0;
            dataE  <= '0;
        end else begin
            validQ <= nextValid;
            if (xfer) begin
                ctrlE <= ctrlD;
                dataE <= dataD;
            end else if (!nextValid) begin
                // Bubbles keep stale data but must never carry side-effecting control.
                ctrlE <= '0;
            end
        end
    end

    assign valid_e     = validQ;
    assign RegWriteE   = ctrlE.regWrite;
    assign ALUSrcE     = ctrlE.aluSrc;
    assign MemWriteE   = ctrlE.memWrite;
    assign ResultSrcE  = ctrlE.resultSrc;
    assign BranchE     = ctrlE.branch;
    assign ALUControlE = ctrlE.aluControl;
    assign RD1_E       = dataE.rd1;
    assign RD2_E       = dataE.rd2;
    assign Imm_Ext_E   = dataE.imm;
    assign PCE         = dataE.pc;
    assign PCPlus4E    = dataE.pcPlus4;
    assign RS1_E       = dataE.rs1;
    assign RS2_E       = dataE.rs2;
    assign RD_E        = dataE.rd;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubbleCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bubbleCnt <= '0;
        else if (!nextValid && bubbleCnt != 32'hFFFF_FFFF)
            bubbleCnt <= bubbleCnt + 32'd1;
    end

    assign bubble_cnt = bubbleCnt;
`else
    // No counter state in this build.
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed table-driven bench for id_ex_pipe_reg, plus reset and counter sequences.
module tb_id_ex_pipe_reg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } data_t;

    // ctl = {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[2:0]}
    typedef struct {
        logic       vd, fl, re;
        logic [7:0] ctl;
        int         seed;
        logic       expRdy, expV;
        logic [7:0] expCtl;
        int         expSeed;
    } vec_t;

    logic clk = 0, rst = 0;
    logic valid_d = 0, flush_e = 0, ready_e = 0;
    logic RegWriteD = 0, ALUSrcD = 0, MemWriteD = 0, ResultSrcD = 0, BranchD = 0;
    logic [2:0] ALUControlD = 0;
    logic [XLEN-1:0] RD1_D = 0, RD2_D = 0, Imm_Ext_D = 0, PCD = 0, PCPlus4D = 0;
    logic [4:0] RS1_D = 0, RS2_D = 0, RD_D = 0;
    logic ready_d, valid_e;
    logic RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0] ALUControlE;
    logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0] RS1_E, RS2_E, RD_E;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int nVec = 0, nBad = 0;
    vec_t vecs[16];

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .ready_d(ready_d),
        .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD),
        .ResultSrcD(ResultSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_Ext_D(Imm_Ext_D), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
        .flush_e(flush_e), .ready_e(ready_e), .valid_e(valid_e),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    // Stimulus encoding: every data field derives from one seed; seed 0 is all-zero.
    function automatic data_t dataOf(input int seed);
        logic [31:0] s;
        s = seed;
        return '{s, s * 2, s * 3, s * 4, s * 5, s[4:0], s[5:1], s[6:2]};
    endfunction

    function automatic logic [7:0] ctlE();
        return {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE};
    endfunction

    function automatic data_t dataE();
        return '{RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RS1_E, RS2_E, RD_E};
    endfunction

    task automatic drive(input logic vd, input logic fl, input logic re,
                         input logic [7:0] ctl, input int seed);
        data_t d;
        d = dataOf(seed);
        valid_d = vd; flush_e = fl; ready_e = re;
        {RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, ALUControlD} = ctl;
        {RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D, RS1_D, RS2_D, RD_D} = d;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        //          vd fl re ctl    seed | rdy v  ctl    seed
        vecs[0]  = '{1, 0, 1, 8'h80, 5,    1,  1, 8'h80, 5};
        vecs[1]  = '{1, 0, 1, 8'h4B, 9,    1,  1, 8'h4B, 9};
        vecs[2]  = '{0, 0, 1, 8'hFF, 7,    1,  0, 8'h00, 9};
        vecs[3]  = '{0, 0, 0, 8'hFF, 7,    1,  0, 8'h00, 9};
        vecs[4]  = '{1, 0, 0, 8'hA3, 12,   1,  1, 8'hA3, 12};
        vecs[5]  = '{1, 0, 0, 8'h11, 20,   0,  1, 8'hA3, 12};
        vecs[6]  = '{1, 0, 0, 8'h11, 20,   0,  1, 8'hA3, 12};
        vecs[7]  = '{1, 0, 0, 8'h11, 20,   0,  1, 8'hA3, 12};
        vecs[8]  = '{1, 0, 1, 8'h11, 20,   1,  1, 8'h11, 20};
        vecs[9]  = '{1, 1, 0, 8'h20, 30,   0,  0, 8'h00, 20};
        vecs[10] = '{0, 0, 1, 8'h00, 0,    1,  0, 8'h00, 20};
        vecs[11] = '{1, 1, 1, 8'h20, 31,   1,  0, 8'h00, 20};
        vecs[12] = '{1, 0, 1, 8'hE7, 40,   1,  1, 8'hE7, 40};
        vecs[13] = '{0, 1, 0, 8'h00, 0,    0,  0, 8'h00, 40};
        vecs[14] = '{1, 0, 0, 8'h08, 50,   1,  1, 8'h08, 50};
        vecs[15] = '{0, 0, 0, 8'h00, 0,    0,  1, 8'h08, 50};

        // Reset state, asserted from time 0.
        #2;
        chk("rst_valid_e", valid_e, 1'b0);
        chk("rst_ctl", ctlE(), 8'h00);
        chk("rst_data", dataE(), '0);
        chk("rst_ready_d", ready_d, 1'b1);
        @(negedge clk); rst = 1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].vd, vecs[i].fl, vecs[i].re, vecs[i].ctl, vecs[i].seed);
            #1 chk($sformatf("v%0d_ready_d", i), ready_d, vecs[i].expRdy);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_e", i), valid_e, vecs[i].expV);
            chk($sformatf("v%0d_ctl", i), ctlE(), vecs[i].expCtl);
            chk($sformatf("v%0d_data", i), dataE(), dataOf(vecs[i].expSeed));
        end

        // Asynchronous reset mid-cycle while holding a valid bundle.
        @(negedge clk); #1 rst = 0;
        #1;
        chk("async_rst_valid_e", valid_e, 1'b0);
        chk("async_rst_ctl", ctlE(), 8'h00);
        chk("async_rst_data", dataE(), '0);
        @(negedge clk);
        rst = 1;
        drive(1, 0, 1, 8'h80, 60);
        #1 chk("resume_ready_d", ready_d, 1'b1);
        @(posedge clk); #1;
        chk("resume_valid_e", valid_e, 1'b1);
        chk("resume_data", dataE(), dataOf(60));

`ifdef ID_EX_PERF_CNT_EN
        @(negedge clk); rst = 0; drive(0, 0, 0, 8'h00, 0);
        #1 chk("cnt_rst", bubble_cnt, 32'd0);
        @(negedge clk); rst = 1;
        repeat (4) @(posedge clk);
        @(negedge clk); drive(1, 0, 1, 8'h80, 1);
        @(negedge clk); drive(1, 0, 1, 8'h80, 2);
        @(posedge clk); #1;
        chk("cnt_after_idle", bubble_cnt, 32'd4);
        @(negedge clk);
        drive(0, 0, 1, 8'h00, 0);
        force dut.bubbleCnt = 32'hFFFF_FFFD;
        #1 release dut.bubbleCnt;
        repeat (4) @(posedge clk);
        #1 chk("cnt_saturate", bubble_cnt, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
